// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, byte-class thresholds, FSM encodings
// and the assembled message word layout.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // 0xF0-0xF7 system common / SysEx, 0xF8-0xFF real-time
  localparam logic [7:0] SYS_MIN  = 8'hF0;
  localparam logic [7:0] RT_MIN   = 8'hF8;

  typedef enum logic [1:0] {P_IDLE, P_D1, P_D2} parse_st_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} uart_st_t;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
  } midi_msg_t;

  // Program change and channel aftertouch carry a single data byte
  function automatic logic one_data_byte(input logic [7:0] status);
    return (status[7:4] == PROG) || (status[7:4] == CHAN_AT);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI UART receiver: 2-flop synchroniser, mid-bit sampling, 8N1 framing.
// RX_VALID / FRAME_ERR are single-cycle strobes asserted in the cycle whose
// rising edge takes the stop-bit sample.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  output logic [7:0] RX_BYTE,
  output logic       RX_VALID,
  output logic       FRAME_ERR
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int CW      = $clog2(BIT_DIV);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_DIV / 2 - 1);

  logic          sync1, sync2;
  uart_st_t      st_q, st_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          brk_q;     // stop bit was low; wait for the line to go high
  logic          tick;

  assign tick    = (cnt_q == '0);
  assign RX_BYTE = shreg_q;

  // Synchronise the asynchronous line; idles high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      sync2 <= sync1;
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) st_q <= R_IDLE;
    else     st_q <= st_d;
  end

  // Next state and framing strobes
  always_comb begin
    st_d      = st_q;
    RX_VALID  = 1'b0;
    FRAME_ERR = 1'b0;
    case (st_q)
      R_IDLE:  if (!sync2) st_d = R_START;
      R_START: if (tick) st_d = sync2 ? R_IDLE : R_DATA;
      R_DATA:  if (tick && bit_q == 3'd7) st_d = R_STOP;
      R_STOP: begin
        if (brk_q) begin
          if (sync2) st_d = R_IDLE;
        end else if (tick) begin
          RX_VALID  = sync2;
          FRAME_ERR = !sync2;
          if (sync2) st_d = R_IDLE;
        end
      end
      default: st_d = R_IDLE;
    endcase
  end

  // Bit timing counter, bit index and shift register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      brk_q   <= 1'b0;
    end else begin
      case (st_q)
        R_IDLE: begin
          cnt_q <= HALF_M1;
          brk_q <= 1'b0;
        end
        R_START: begin
          if (tick) begin
            cnt_q <= FULL_M1;
            bit_q <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        R_DATA: begin
          if (tick) begin
            shreg_q <= {sync2, shreg_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            cnt_q   <= FULL_M1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        R_STOP: begin
          if (!tick)       cnt_q <= cnt_q - CW'(1);
          else if (!sync2) brk_q <= 1'b1;
        end
        default: cnt_q <= HALF_M1;
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_assembler.sv
// MIDI message assembler: UART front end plus channel-voice parser that emits
// {status, data1, data2} with a one-cycle ready strobe.
// Build option MIDI_RUNNING_STATUS_EN: data bytes arriving with no message in
// progress reuse the last channel status (running status).
module midi_msg_assembler
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31250
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MIDI_IN,
  output logic [23:0] MIDI_MSG,
  output logic        MIDI_MSG_RDY,
  output logic        FRAME_ERR
);

`ifdef MIDI_RUNNING_STATUS_EN
  localparam logic RUN_STAT = 1'b1;
`else
  localparam logic RUN_STAT = 1'b0;
`endif

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (MIDI_IN),
    .RX_BYTE   (rx_byte),
    .RX_VALID  (rx_valid),
    .FRAME_ERR (rx_ferr)
  );

  parse_st_t  st_q, st_d;
  logic [7:0] status_q, status_d, d1_q, d1_d;
  logic       vld_q, vld_d;
  midi_msg_t  msg_q, msg_d;
  logic       rdy_q, rdy_d, ferr_q;
  logic       as_d1;

  assign MIDI_MSG     = msg_q;
  assign MIDI_MSG_RDY = rdy_q;
  assign FRAME_ERR    = ferr_q;

  // Parser and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q     <= P_IDLE;
      status_q <= '0;
      vld_q    <= 1'b0;
      d1_q     <= '0;
      msg_q    <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      status_q <= status_d;
      vld_q    <= vld_d;
      d1_q     <= d1_d;
      msg_q    <= msg_d;
      rdy_q    <= rdy_d;
      ferr_q   <= rx_ferr;
    end
  end

  // Byte classification, next state and emit
  always_comb begin
    st_d     = st_q;
    status_d = status_q;
    vld_d    = vld_q;
    d1_d     = d1_q;
    msg_d    = msg_q;
    rdy_d    = 1'b0;
    as_d1    = 1'b0;
    if (rx_valid && rx_byte < RT_MIN) begin
      if (rx_byte >= SYS_MIN) begin
        vld_d = 1'b0;
        st_d  = P_IDLE;
      end else if (rx_byte[7]) begin
        status_d = rx_byte;
        vld_d    = 1'b1;
        st_d     = P_D1;
      end else begin
        as_d1 = (st_q == P_D1) || (st_q == P_IDLE && vld_q && RUN_STAT);
        if (as_d1) begin
          d1_d = rx_byte;
          if (one_data_byte(status_q)) begin
            msg_d = '{status: status_q, data1: rx_byte, data2: 8'h00};
            rdy_d = 1'b1;
            st_d  = P_IDLE;
          end else begin
            st_d = P_D2;
          end
        end else if (st_q == P_D2) begin
          msg_d = '{status: status_q, data1: d1_q, data2: rx_byte};
          rdy_d = 1'b1;
          st_d  = P_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Scoreboard bench for midi_msg_assembler: the stimulus pushes expected
// messages / frame errors with their expected cycle, a monitor pops on pulses.
module tb_midi_msg_assembler;

  localparam int CLK_HZ  = 2_000_000;
  localparam int BAUD    = 31250;
  localparam int BIT_DIV = CLK_HZ / BAUD;                  // 64
  // start-edge drive -> output pulse: 2 sync flops + idle detect edge,
  // half a bit to the start sample, then 9 full bits to the stop sample
  localparam int LAT     = 3 + BIT_DIV / 2 + 9 * BIT_DIV;  // 611

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MIDI_IN = 1'b1;
  logic [23:0] MIDI_MSG;
  logic        MIDI_MSG_RDY;
  logic        FRAME_ERR;

  midi_msg_assembler #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .MIDI_IN      (MIDI_IN),
    .MIDI_MSG     (MIDI_MSG),
    .MIDI_MSG_RDY (MIDI_MSG_RDY),
    .FRAME_ERR    (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] msg;
    int          at;
  } exp_t;

  exp_t msg_sb[$];
  int   ferr_sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Send one 8N1 frame; optionally register the pulse it must produce
  task automatic xfer(input logic [7:0] b, input logic stop_bit,
                      input logic emit, input logic [23:0] msg);
    exp_t e;
    @(negedge CLK);
    MIDI_IN = 1'b0;
    if (emit) begin
      e.msg = msg;
      e.at  = cyc + LAT;
      msg_sb.push_back(e);
    end
    if (!stop_bit) ferr_sb.push_back(cyc + LAT);
    repeat (BIT_DIV) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      MIDI_IN = b[i];
      repeat (BIT_DIV) @(negedge CLK);
    end
    MIDI_IN = stop_bit;
    repeat (BIT_DIV) @(negedge CLK);
    MIDI_IN = 1'b1;
  endtask

  task automatic tx(input logic [7:0] b);
    xfer(b, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic tx_e(input logic [7:0] b, input logic [23:0] msg);
    xfer(b, 1'b1, 1'b1, msg);
  endtask

  // Monitor: every pulse must match the head of its scoreboard queue
  always @(negedge CLK) begin
    if (!RST) begin
      if (MIDI_MSG_RDY) begin
        if (msg_sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rdy_unexpected: got msg %h with no pending message (cycle %0d)", MIDI_MSG, cyc);
        end else begin
          exp_t e;
          e = msg_sb.pop_front();
          check("rdy_msg", {8'h0, MIDI_MSG}, {8'h0, e.msg});
          check("rdy_cycle", cyc, e.at);
        end
      end
      if (FRAME_ERR) begin
        if (ferr_sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ferr_unexpected: got pulse with none pending (cycle %0d)", cyc);
        end else begin
          check("ferr_cycle", cyc, ferr_sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_msg", {8'h0, MIDI_MSG}, 32'h0);
    check("reset_rdy", {31'h0, MIDI_MSG_RDY}, 32'h0);
    check("reset_ferr", {31'h0, FRAME_ERR}, 32'h0);
    RST = 1'b0;
    repeat (20) @(negedge CLK);

    // 1: basic 3-byte note-on
    tx(8'h90); tx(8'h3C); tx_e(8'h64, 24'h903C64);

    // 2: 2-byte program change, then real-time byte inside a note-off
    tx(8'hC5); tx_e(8'h07, 24'hC50700);
    tx(8'h80); tx(8'h3C); tx(8'hF8); tx_e(8'h40, 24'h803C40);
    repeat (200) @(negedge CLK);
    check("hold_msg", {8'h0, MIDI_MSG}, 32'h00803C40);

    // 3: running status
    tx(8'h90); tx(8'h3C); tx_e(8'h64, 24'h903C64);
    tx(8'h3E);
`ifdef MIDI_RUNNING_STATUS_EN
    tx_e(8'h50, 24'h903E50);
`else
    tx(8'h50);
`endif

    // 4: SysEx kills the partial message and the stored status
    tx(8'h90); tx(8'h3C);
    tx(8'hF0); tx(8'h01); tx(8'h02); tx(8'hF7);
    tx(8'h40); tx(8'h7F);
    tx(8'h91); tx(8'h40); tx_e(8'h7F, 24'h91407F);

    // 5: framing error leaves the parser alone; short glitch is ignored
    tx(8'h90); tx(8'h3C);
    xfer(8'h55, 1'b0, 1'b0, 24'h0);
    repeat (BIT_DIV) @(negedge CLK);
    tx_e(8'h64, 24'h903C64);
    repeat (50) @(negedge CLK);
    MIDI_IN = 1'b0;
    repeat (20) @(negedge CLK);
    MIDI_IN = 1'b1;
    repeat (200) @(negedge CLK);
    tx(8'h92); tx(8'h10); tx_e(8'h20, 24'h921020);

    // 6: reset mid-message
    tx(8'h90);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("midreset_msg", {8'h0, MIDI_MSG}, 32'h0);
    check("midreset_rdy", {31'h0, MIDI_MSG_RDY}, 32'h0);
    check("midreset_ferr", {31'h0, FRAME_ERR}, 32'h0);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    tx(8'h3C); tx(8'h64);

    repeat (700) @(negedge CLK);
    check("pending_msgs", msg_sb.size(), 32'h0);
    check("pending_ferr", ferr_sb.size(), 32'h0);
    check("final_msg", {8'h0, MIDI_MSG}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
